// File: rtl/doodle_vertical_ctrl_if.sv
// Signal bundle between the bump integrator / game logic and the doodle vertical controller.
// The controller itself uses the slave modport.
interface doodle_vertical_ctrl_if;
    logic       frame_tick;
    logic       start;
    logic [2:0] bump;
    logic [9:0] movement;
    logic [9:0] doodle_y;
    logic [4:0] speed_y;
    logic       fly;
    logic [1:0] jump_state;
    logic [9:0] scroll_amt;
    logic       land_pulse;
    logic       break_pulse;
    logic       game_over;

    modport master (
        output frame_tick, start, bump, movement,
        input  doodle_y, speed_y, fly, jump_state, scroll_amt,
        input  land_pulse, break_pulse, game_over
    );

    modport slave (
        input  frame_tick, start, bump, movement,
        output doodle_y, speed_y, fly, jump_state, scroll_amt,
        output land_pulse, break_pulse, game_over
    );
endinterface

// File: rtl/doodle_vertical_ctrl.sv
// Doodle vertical motion: jump launch, gravity, screen-scroll clamp, bounces and floor death.
//   state | meaning
//   IDLE  | waiting on the start pad for the first launch
//   RISE  | moving up, speed decays by GRAVITY each frame
//   FALL  | moving down, accepts bumps, speed grows to MAX_FALL
//   DEAD  | hit the floor, waiting for restart
module doodle_vertical_ctrl #(
    parameter int unsigned START_Y  = 400,
    parameter int unsigned JUMP_V   = 16,
    parameter int unsigned SPRING_V = 28,
    parameter int unsigned GRAVITY  = 1,
    parameter int unsigned MAX_FALL = 12,
    parameter int unsigned SCROLL_Y = 160,
    parameter int unsigned FLOOR_Y  = 470
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    doodle_vertical_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RISE = 2'd1,
        S_FALL = 2'd2,
        S_DEAD = 2'd3
    } state_t;

    localparam logic [9:0]  P_START  = 10'(START_Y);
    localparam logic [4:0]  P_JUMP   = 5'(JUMP_V);
    localparam logic [4:0]  P_SPRING = 5'(SPRING_V);
    localparam logic [4:0]  P_GRAV   = 5'(GRAVITY);
    localparam logic [4:0]  P_MAXF   = 5'(MAX_FALL);
    localparam logic [9:0]  P_SCROLL = 10'(SCROLL_Y);
    localparam logic [10:0] P_FLOOR  = 11'(FLOOR_Y);

    state_t     r_state;
    logic [9:0] r_y;
    logic [4:0] r_speed;
    logic       r_fly;
    logic [9:0] r_scroll;
    logic       r_land;
    logic       r_break;
    logic       r_over;

    logic [9:0]  w_rise_top;
    logic        w_rise_clamp;
    logic [9:0]  w_scroll;
    logic [10:0] w_fall_sum;
    logic [4:0]  w_speed_inc;
    logic [4:0]  w_speed_fall;
    logic        w_bounce;

    // Compare speed + SCROLL_Y against y instead of speed against y - SCROLL_Y,
    // so nothing can go negative even if y ever sits above the scroll line.
    assign w_rise_top   = {5'd0, r_speed} + P_SCROLL;
    assign w_rise_clamp = w_rise_top > r_y;
    assign w_scroll     = w_rise_top - r_y;
    assign w_fall_sum   = {1'b0, r_y} + {6'd0, r_speed};
    assign w_speed_inc  = r_speed + P_GRAV;
    assign w_speed_fall = (w_speed_inc > P_MAXF) ? P_MAXF : w_speed_inc;
    assign w_bounce     = (bus.bump == 3'd1) || (bus.bump == 3'd2) || (bus.bump == 3'd4);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_y      <= P_START;
            r_speed  <= 5'd0;
            r_fly    <= 1'b0;
            r_scroll <= 10'd0;
            r_land   <= 1'b0;
            r_break  <= 1'b0;
            r_over   <= 1'b0;
        end else begin
            r_scroll <= 10'd0;
            r_land   <= 1'b0;
            r_break  <= 1'b0;
            if (bus.frame_tick) begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_state <= S_RISE;
                            r_speed <= P_JUMP;
                            r_fly   <= 1'b1;
                        end
                    end
                    S_RISE: begin
                        if (r_speed <= P_GRAV) begin
                            r_state <= S_FALL;
                            r_speed <= 5'd0;
                            r_fly   <= 1'b0;
                        end else begin
                            if (w_rise_clamp) begin
                                r_y      <= P_SCROLL;
                                r_scroll <= w_scroll;
                            end else begin
                                r_y <= r_y - {5'd0, r_speed};
                            end
                            r_speed <= r_speed - P_GRAV;
                        end
                    end
                    S_FALL: begin
                        // Bounce wins over the floor check, even below the floor line.
                        if (w_bounce) begin
                            r_state <= S_RISE;
                            r_y     <= r_y + bus.movement;
                            r_speed <= (bus.bump == 3'd4) ? P_SPRING : P_JUMP;
                            r_fly   <= 1'b1;
                            r_land  <= 1'b1;
                        end else begin
                            r_break <= (bus.bump == 3'd3);
                            if (w_fall_sum >= P_FLOOR) begin
                                r_state <= S_DEAD;
                                r_y     <= P_FLOOR[9:0];
                                r_speed <= 5'd0;
                                r_over  <= 1'b1;
                            end else begin
                                r_y     <= w_fall_sum[9:0];
                                r_speed <= w_speed_fall;
                            end
                        end
                    end
                    S_DEAD: begin
                        if (bus.start) begin
                            r_state <= S_IDLE;
                            r_y     <= P_START;
                            r_speed <= 5'd0;
                            r_fly   <= 1'b0;
                            r_over  <= 1'b0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.doodle_y    = r_y;
    assign bus.speed_y     = r_speed;
    assign bus.fly         = r_fly;
    assign bus.jump_state  = r_state;
    assign bus.scroll_amt  = r_scroll;
    assign bus.land_pulse  = r_land;
    assign bus.break_pulse = r_break;
    assign bus.game_over   = r_over;
endmodule

// File: tb/tb_doodle_vertical_ctrl.sv
// Directed bench for doodle_vertical_ctrl: per-frame vector table plus death/restart/reset sequences.
module tb_doodle_vertical_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    doodle_vertical_ctrl_if bus ();

    doodle_vertical_ctrl dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       start;
        logic [2:0] bump;
        logic [9:0] mov;
        logic [9:0] y;
        logic [4:0] spd;
        logic       fly;
        logic [1:0] st;
        logic [9:0] scr;
        logic       land;
        logic       brk;
        logic       go;
    } vec_t;

    vec_t tbl[45];

    function automatic vec_t v(input logic tick, input logic start, input logic [2:0] bump,
                               input logic [9:0] mov, input logic [9:0] y, input logic [4:0] spd,
                               input logic fly, input logic [1:0] st, input logic [9:0] scr,
                               input logic land, input logic brk, input logic go);
        vec_t r;
        r.tick = tick; r.start = start; r.bump = bump; r.mov = mov;
        r.y = y; r.spd = spd; r.fly = fly; r.st = st; r.scr = scr;
        r.land = land; r.brk = brk; r.go = go;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, " doodle_y"},    int'(bus.doodle_y),    int'(e.y));
        chk({tag, " speed_y"},     int'(bus.speed_y),     int'(e.spd));
        chk({tag, " fly"},         int'(bus.fly),         int'(e.fly));
        chk({tag, " jump_state"},  int'(bus.jump_state),  int'(e.st));
        chk({tag, " scroll_amt"},  int'(bus.scroll_amt),  int'(e.scr));
        chk({tag, " land_pulse"},  int'(bus.land_pulse),  int'(e.land));
        chk({tag, " break_pulse"}, int'(bus.break_pulse), int'(e.brk));
        chk({tag, " game_over"},   int'(bus.game_over),   int'(e.go));
    endtask

    task automatic step(input logic tick, input logic start, input logic [2:0] bump, input logic [9:0] mov);
        bus.frame_tick = tick;
        bus.start      = start;
        bus.bump       = bump;
        bus.movement   = mov;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.bump       = 3'd0;
        bus.movement   = 10'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0, 3'd0, 10'd0);
        step(1'b0, 1'b0, 3'd0, 10'd0);
        rst_n = 1'b1;
    endtask

    // Launch from reset and ride the full jump to its apex (lands in FALL at y = 265).
    task automatic launch_to_fall();
        do_reset();
        step(1'b1, 1'b1, 3'd0, 10'd0);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 3'd0, 10'd0);
        chk("apex state", int'(bus.jump_state), 2);
        chk("apex y", int'(bus.doodle_y), 265);
    endtask

    task automatic fall_to_463();
        for (int i = 0; i < 40; i++) begin
            if (bus.doodle_y == 10'd463 || bus.jump_state != 2'd2) break;
            step(1'b1, 1'b0, 3'd0, 10'd0);
        end
        chk("pre-floor y", int'(bus.doodle_y), 463);
        chk("pre-floor speed", int'(bus.speed_y), 12);
        chk("pre-floor state", int'(bus.jump_state), 2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.bump       = 3'd0;
        bus.movement   = 10'd0;

        //              tick st bump mov   y   spd fly st scr land brk go
        tbl[0]  = v(1, 0, 0, 0, 400,  0, 0, 0,  0, 0, 0, 0);
        tbl[1]  = v(1, 1, 0, 0, 400, 16, 1, 1,  0, 0, 0, 0);
        tbl[2]  = v(1, 1, 1, 5, 384, 15, 1, 1,  0, 0, 0, 0);
        tbl[3]  = v(1, 0, 0, 0, 369, 14, 1, 1,  0, 0, 0, 0);
        tbl[4]  = v(1, 0, 0, 0, 355, 13, 1, 1,  0, 0, 0, 0);
        tbl[5]  = v(1, 0, 0, 0, 342, 12, 1, 1,  0, 0, 0, 0);
        tbl[6]  = v(1, 0, 0, 0, 330, 11, 1, 1,  0, 0, 0, 0);
        tbl[7]  = v(1, 0, 0, 0, 319, 10, 1, 1,  0, 0, 0, 0);
        tbl[8]  = v(1, 0, 0, 0, 309,  9, 1, 1,  0, 0, 0, 0);
        tbl[9]  = v(1, 0, 0, 0, 300,  8, 1, 1,  0, 0, 0, 0);
        tbl[10] = v(1, 0, 0, 0, 292,  7, 1, 1,  0, 0, 0, 0);
        tbl[11] = v(1, 0, 0, 0, 285,  6, 1, 1,  0, 0, 0, 0);
        tbl[12] = v(1, 0, 0, 0, 279,  5, 1, 1,  0, 0, 0, 0);
        tbl[13] = v(1, 0, 0, 0, 274,  4, 1, 1,  0, 0, 0, 0);
        tbl[14] = v(1, 0, 0, 0, 270,  3, 1, 1,  0, 0, 0, 0);
        tbl[15] = v(1, 0, 0, 0, 267,  2, 1, 1,  0, 0, 0, 0);
        tbl[16] = v(1, 0, 0, 0, 265,  1, 1, 1,  0, 0, 0, 0);
        tbl[17] = v(1, 0, 0, 0, 265,  0, 0, 2,  0, 0, 0, 0);
        tbl[18] = v(1, 0, 0, 0, 265,  1, 0, 2,  0, 0, 0, 0);
        tbl[19] = v(1, 0, 0, 0, 266,  2, 0, 2,  0, 0, 0, 0);
        tbl[20] = v(1, 0, 0, 0, 268,  3, 0, 2,  0, 0, 0, 0);
        tbl[21] = v(1, 0, 0, 0, 271,  4, 0, 2,  0, 0, 0, 0);
        tbl[22] = v(1, 0, 0, 0, 275,  5, 0, 2,  0, 0, 0, 0);
        tbl[23] = v(1, 0, 3, 9, 280,  6, 0, 2,  0, 0, 1, 0);
        tbl[24] = v(1, 0, 1, 3, 283, 16, 1, 1,  0, 1, 0, 0);
        tbl[25] = v(1, 0, 0, 0, 267, 15, 1, 1,  0, 0, 0, 0);
        tbl[26] = v(1, 0, 0, 0, 252, 14, 1, 1,  0, 0, 0, 0);
        tbl[27] = v(1, 0, 0, 0, 238, 13, 1, 1,  0, 0, 0, 0);
        tbl[28] = v(1, 0, 0, 0, 225, 12, 1, 1,  0, 0, 0, 0);
        tbl[29] = v(1, 0, 0, 0, 213, 11, 1, 1,  0, 0, 0, 0);
        tbl[30] = v(1, 0, 0, 0, 202, 10, 1, 1,  0, 0, 0, 0);
        tbl[31] = v(1, 0, 0, 0, 192,  9, 1, 1,  0, 0, 0, 0);
        tbl[32] = v(1, 0, 0, 0, 183,  8, 1, 1,  0, 0, 0, 0);
        tbl[33] = v(1, 0, 0, 0, 175,  7, 1, 1,  0, 0, 0, 0);
        tbl[34] = v(1, 0, 0, 0, 168,  6, 1, 1,  0, 0, 0, 0);
        tbl[35] = v(1, 0, 0, 0, 162,  5, 1, 1,  0, 0, 0, 0);
        tbl[36] = v(1, 0, 0, 0, 160,  4, 1, 1,  3, 0, 0, 0);
        tbl[37] = v(1, 0, 0, 0, 160,  3, 1, 1,  4, 0, 0, 0);
        tbl[38] = v(1, 0, 0, 0, 160,  2, 1, 1,  3, 0, 0, 0);
        tbl[39] = v(1, 0, 0, 0, 160,  1, 1, 1,  2, 0, 0, 0);
        tbl[40] = v(1, 0, 0, 0, 160,  0, 0, 2,  0, 0, 0, 0);
        tbl[41] = v(1, 0, 4, 2, 162, 28, 1, 1,  0, 1, 0, 0);
        tbl[42] = v(1, 0, 0, 0, 160, 27, 1, 1, 26, 0, 0, 0);
        tbl[43] = v(1, 0, 0, 0, 160, 26, 1, 1, 27, 0, 0, 0);
        tbl[44] = v(0, 1, 0, 0, 160, 26, 1, 1,  0, 0, 0, 0);

        do_reset();
        chk_all("reset", v(0, 0, 0, 0, 400, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 45; i++) begin
            step(tbl[i].tick, tbl[i].start, tbl[i].bump, tbl[i].mov);
            chk_all($sformatf("vec%0d", i), tbl[i]);
        end

        // Fall to the floor, sit in DEAD, then restart.
        launch_to_fall();
        fall_to_463();
        step(1'b1, 1'b0, 3'd0, 10'd0);
        chk_all("death", v(0, 0, 0, 0, 470, 0, 0, 3, 0, 0, 0, 1));
        step(1'b1, 1'b0, 3'd1, 10'd5);
        chk_all("dead hold bump", v(0, 0, 0, 0, 470, 0, 0, 3, 0, 0, 0, 1));
        step(1'b0, 1'b1, 3'd0, 10'd0);
        chk_all("dead start no tick", v(0, 0, 0, 0, 470, 0, 0, 3, 0, 0, 0, 1));
        step(1'b1, 1'b1, 3'd0, 10'd0);
        chk_all("restart", v(0, 0, 0, 0, 400, 0, 0, 0, 0, 0, 0, 0));

        // Bounce landing below the floor line still bounces.
        launch_to_fall();
        fall_to_463();
        step(1'b1, 1'b0, 3'd1, 10'd10);
        chk_all("floor bounce", v(0, 0, 0, 0, 473, 16, 1, 1, 0, 1, 0, 0));
        step(1'b1, 1'b0, 3'd0, 10'd0);
        chk_all("floor bounce rise", v(0, 0, 0, 0, 457, 15, 1, 1, 0, 0, 0, 0));

        // Reset asserted mid-rise together with a tick and start.
        step(1'b1, 1'b0, 3'd0, 10'd0);
        rst_n = 1'b0;
        step(1'b1, 1'b1, 3'd4, 10'd7);
        rst_n = 1'b1;
        chk_all("reset mid-rise", v(0, 0, 0, 0, 400, 0, 0, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
